// File: rtl/tff_ctrl_pkg.sv
// Shared types and constants for the T-flip-flop count controller.
package tff_ctrl_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/tff_count_ctrl_cell.sv
// Single T flip-flop: toggles when t_in is high, synchronous clear.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t_in,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= q ^ t_in;
        end
    end

endmodule

// File: rtl/tff_count_ctrl.sv
// Up/down counter built from a T flip-flop bank, sequenced by an
// IDLE/RUN controller with oneshot or auto-reload terminal handling.
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] tc,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic             up_q, up_d;
    logic             os_q, os_d;

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] t_up, t_dn;
    logic [WIDTH-1:0] init_q, end_q;
    logic             at_end;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .t_in (t[i]),
            .q    (q[i])
        );
    end

    // Ripple-carry/borrow toggle enables for +1 and -1.
    always_comb begin
        logic cu, cd;
        cu = 1'b1;
        cd = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t_up[i] = cu;
            t_dn[i] = cd;
            cu = cu & q[i];
            cd = cd & ~q[i];
        end
    end

    assign init_q = up_q ? '0 : tc_q;
    assign end_q  = up_q ? tc_q : '0;
    assign at_end = (q == end_q);
    assign busy   = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        up_d    = up_q;
        os_d    = os_q;
        t       = '0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    tc_d    = tc;
                    up_d    = up_dn;
                    os_d    = oneshot;
                    t       = q ^ (up_dn ? '0 : tc);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (at_end) begin
                    done = 1'b1;
                    if (os_q) begin
                        state_d = IDLE;
                    end else begin
                        t = q ^ init_q;
                    end
                end else begin
                    t = up_q ? t_up : t_dn;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tc_q    <= '0;
            up_q    <= 1'b0;
            os_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            up_q    <= up_d;
            os_q    <= os_d;
        end
    end

endmodule
